qwi_regbus_arb: RTL and testbench
=================================

// Module: qwi_regbus_arb
// PURPOSE
//  Round-robin arbiter and sequencer that shares one register-control bus (reg_ce/reg_we/reg_addr/
//  reg_wrd/reg_rdd) between NREQ masters (e.g. UART command parser, AXI-lite bridge, init ROM).
//  Sits directly in front of the register bank. Serialises single-beat reads/writes with a
//  valid/ready request and a one-cycle response pulse. Rejects out-of-range addresses without a bus cycle.
// PARAMETERS
//  NREQ    2   number of requesting masters (>=2)
//  REGCNT  32  number of registers in the target bank; valid addr range 0..REGCNT-1
//  AWID    12  register address width
//  DWID    32  register data width (multiple of 8)
// PORTS
//  reg_clk    in   1          single clock for the block and the register bank
//  sys_rst    in   1          reset, asynchronous, active-high
//  req_vld    in   NREQ       per-master request valid; held with fields until req_rdy
//  req_wr     in   NREQ       per-master 1=write, 0=read
//  req_addr   in   NREQ*AWID  per-master address, master i at [AWID*(i+1)-1 -: AWID]
//  req_wrd    in   NREQ*DWID  per-master write data, same packing
//  req_rdy    out  NREQ       one-hot accept pulse (combinational in IDLE)
//  rsp_vld    out  NREQ       one-hot response pulse to granted master
//  rsp_err    out  1          with rsp_vld: address out of range
//  rsp_rdd    out  DWID       with rsp_vld: register value read during the bus cycle
//  busy       out  1          high in any state other than IDLE
//  reg_ce     out  1          bus chip enable to register bank
//  reg_we     out  DWID/8     bus byte write enables (all ones or all zeros)
//  reg_addr   out  AWID       bus address
//  reg_wrd    out  DWID       bus write data
//  reg_rdd    in   DWID       bus read data; combinational from the bank on reg_addr
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, ptr=NREQ-1, all outputs 0; in-flight txn dropped,
//   no rsp_vld for it; master must reissue.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction every 3 cycles; never idles if requests pend.
//  IDLE: if |req_vld, gnt = first set bit searching ptr+1, ptr+2, ... mod NREQ. req_rdy[gnt]=1
//   this cycle only. Latch gnt, wr, addr, wrd, err=(addr>=REGCNT). Set ptr=gnt. Go to ISSUE.
//   If no request, stay in IDLE with req_rdy=0.
//  ISSUE: when !err, reg_ce=1, reg_addr/reg_wrd=latched, reg_we={DWID/8{wr}}. reg_rdd sampled
//   at the end of the cycle into rsp_rdd (pre-write value for writes). When err, reg_ce=0,
//   reg_we=0, rsp_rdd<=0. All bus outputs are registered and are 0 outside ISSUE.
//  RESP: rsp_vld[gnt]=1 and rsp_err=err for exactly 1 cycle. rsp_rdd holds until the next RESP.
//   Then go to IDLE.
//  Latency: req accept (cycle N) -> bus cycle N+1 -> response N+2.
//  Write visibility: the write lands in the bank at the end of N+1. A read accepted at any later
//   IDLE returns the new value.
//  Simultaneous requests: exactly one granted per IDLE cycle. Losers keep req_vld high and
//   stay pending. Fairness: with all masters requesting, grants rotate 0,1,..,NREQ-1.
//  req_vld deasserting while not accepted: legal, no effect. Field changes after accept are ignored.
//  reg_addr bits wider than log2(REGCNT) are compared in full (no wrap or aliasing).
// STRUCTURE
//  Shared include (Define.vh style): FSM state encodings ST_IDLE/ST_ISSUE/ST_RESP (2-bit) and
//   the clog2 helper function.
//  Sub-module qwi_rr_pick: combinational round-robin picker (req[NREQ], ptr -> one-hot gnt,
//   index, any). Top holds the FSM, latches and bus registers.
// TESTING
//  1 Reset mid-ISSUE (m0 write addr 3): sys_rst pulse -> all outputs 0 at once, no rsp_vld,
//    busy=0; after release, m0 reissues and is accepted.
//  2 m0 write addr 5 data 0xA5A5_0001, then m1 read addr 5 -> bus cycle reg_ce=1, reg_we=4'hF;
//    m1 rsp_vld with rsp_rdd=0xA5A5_0001, rsp_err=0.
//  3 m0 and m1 both hold req_vld for 6 transactions -> grants 0,1,0,1,0,1. Each rsp_vld arrives
//    2 cycles after its req_rdy. 3-cycle spacing.
//  4 m1 read addr 32 (REGCNT=32) -> reg_ce never asserted; rsp_vld[1]=1, rsp_err=1, rsp_rdd=0;
//    bank contents unchanged.
//  5 m0 read addr 0 with bank reg0=0x1234 -> rsp_rdd=0x1234; a write to addr 0 reports the old
//    value 0x1234, and the next read returns the new data.
//  6 Random mix via scoreboard vs bank model, NREQ=3 -> no lost or duplicated txn; one-hot
//    rsp_vld; no master starved for more than NREQ grants.

Source files
------------

// File: rtl/qwi_regbus_arb_pkg.sv
// Shared definitions for the register-bus arbiter: FSM state encodings and a clog2 helper.
package qwi_regbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic int f_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/qwi_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo NREQ.
module qwi_rr_pick
    import qwi_regbus_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = f_clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = int'(i_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_idx       = cand[IDXW-1:0];
                o_gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qwi_regbus_arb.sv
// Round-robin arbiter sharing one register-control bus between NREQ masters.
// One single-beat transaction per three cycles: accept (IDLE), bus cycle (ISSUE), response (RESP).
module qwi_regbus_arb
    import qwi_regbus_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int REGCNT = 32,
    parameter int AWID   = 12,
    parameter int DWID   = 32
) (
    input  logic                 reg_clk,
    input  logic                 sys_rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*AWID-1:0] req_addr,
    input  logic [NREQ*DWID-1:0] req_wrd,
    output logic [NREQ-1:0]      req_rdy,
    output logic [NREQ-1:0]      rsp_vld,
    output logic                 rsp_err,
    output logic [DWID-1:0]      rsp_rdd,
    output logic                 busy,
    output logic                 reg_ce,
    output logic [DWID/8-1:0]    reg_we,
    output logic [AWID-1:0]      reg_addr,
    output logic [DWID-1:0]      reg_wrd,
    input  logic [DWID-1:0]      reg_rdd
);

    localparam int IDXW = f_clog2(NREQ);
    localparam int BEW  = DWID / 8;
    // One extra bit so REGCNT == 2**AWID is still representable.
    localparam logic [AWID:0] REGCNT_W = (AWID + 1)'(REGCNT);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt_oh;
    logic            r_err;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_pick_any;
    logic            w_sel_wr;
    logic [AWID-1:0] w_sel_addr;
    logic [DWID-1:0] w_sel_wrd;
    logic            w_sel_err;

    qwi_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .i_req (req_vld),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_wrd  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_sel_wr   = req_wr[k];
                w_sel_addr = req_addr[AWID*k +: AWID];
                w_sel_wrd  = req_wrd[DWID*k +: DWID];
            end
        end
    end

    // Full-width compare: high address bits never alias onto a valid register.
    assign w_sel_err = ({1'b0, w_sel_addr} >= REGCNT_W);

    // Accept is combinational in IDLE and suppressed while reset is asserted.
    assign req_rdy = ((r_state == ST_IDLE) && !sys_rst) ? w_pick_gnt : '0;

    always_ff @(posedge reg_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IDXW'(NREQ - 1);
            r_gnt_oh <= '0;
            r_err    <= 1'b0;
            rsp_vld  <= '0;
            rsp_err  <= 1'b0;
            rsp_rdd  <= '0;
            busy     <= 1'b0;
            reg_ce   <= 1'b0;
            reg_we   <= '0;
            reg_addr <= '0;
            reg_wrd  <= '0;
        end else begin
            rsp_vld  <= '0;
            rsp_err  <= 1'b0;
            reg_ce   <= 1'b0;
            reg_we   <= '0;
            reg_addr <= '0;
            reg_wrd  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_ptr    <= w_pick_idx;
                        r_gnt_oh <= w_pick_gnt;
                        r_err    <= w_sel_err;
                        // Bus registers double as the transaction latch for ISSUE.
                        reg_ce   <= !w_sel_err;
                        reg_we   <= {BEW{w_sel_wr & !w_sel_err}};
                        reg_addr <= w_sel_err ? '0 : w_sel_addr;
                        reg_wrd  <= w_sel_err ? '0 : w_sel_wrd;
                        busy     <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_rdd <= r_err ? '0 : reg_rdd;
                    rsp_vld <= r_gnt_oh;
                    rsp_err <= r_err;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qwi_regbus_arb.sv
// Scoreboard bench for qwi_regbus_arb (NREQ=3) with a behavioural register bank and reference model.
module tb_qwi_regbus_arb;

    localparam int NREQ   = 3;
    localparam int REGCNT = 32;
    localparam int AWID   = 12;
    localparam int DWID   = 32;
    localparam int BEW    = DWID / 8;
    localparam int IW     = $clog2(REGCNT);

    typedef struct packed {
        logic            wr;
        logic [AWID-1:0] addr;
        logic [DWID-1:0] wrd;
    } req_t;

    typedef struct packed {
        logic [7:0]      m;
        logic            wr;
        logic [AWID-1:0] addr;
        logic [DWID-1:0] wrd;
        logic            err;
        logic [DWID-1:0] rdd;
        logic [DWID-1:0] old;
        logic [31:0]     acc;
    } exp_t;

    logic                 reg_clk;
    logic                 sys_rst = 1'b1;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*AWID-1:0] req_addr;
    logic [NREQ*DWID-1:0] req_wrd;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ-1:0]      rsp_vld;
    logic                 rsp_err;
    logic [DWID-1:0]      rsp_rdd;
    logic                 busy;
    logic                 reg_ce;
    logic [BEW-1:0]       reg_we;
    logic [AWID-1:0]      reg_addr;
    logic [DWID-1:0]      reg_wrd;
    logic [DWID-1:0]      reg_rdd;

    qwi_regbus_arb #(
        .NREQ   (NREQ),
        .REGCNT (REGCNT),
        .AWID   (AWID),
        .DWID   (DWID)
    ) dut (
        .reg_clk  (reg_clk),
        .sys_rst  (sys_rst),
        .req_vld  (req_vld),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wrd  (req_wrd),
        .req_rdy  (req_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_err  (rsp_err),
        .rsp_rdd  (rsp_rdd),
        .busy     (busy),
        .reg_ce   (reg_ce),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wrd  (reg_wrd),
        .reg_rdd  (reg_rdd)
    );

    initial begin
        reg_clk = 1'b0;
        forever #5 reg_clk = ~reg_clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Register bank: combinational read, write at clock edge.
    logic [DWID-1:0] bank  [REGCNT];
    logic [DWID-1:0] model [REGCNT];

    assign reg_rdd = (reg_addr < AWID'(REGCNT)) ? bank[reg_addr[IW-1:0]] : '0;

    always @(posedge reg_clk) begin
        if (!sys_rst && reg_ce && reg_we == {BEW{1'b1}} && reg_addr < AWID'(REGCNT))
            bank[reg_addr[IW-1:0]] <= reg_wrd;
    end

    int unsigned cyc = 0;
    always @(posedge reg_clk) cyc <= cyc + 1;

    // Master-side stimulus.
    logic [NREQ-1:0] d_vld;
    logic [NREQ-1:0] d_wr;
    logic [AWID-1:0] d_addr [NREQ];
    logic [DWID-1:0] d_wrd  [NREQ];
    req_t            mq [NREQ][$];
    logic [NREQ-1:0] acc_flag = '0;
    bit              withdraw_en = 1'b0;

    assign req_vld = d_vld;
    assign req_wr  = d_wr;
    always_comb begin
        req_addr = '0;
        req_wrd  = '0;
        for (int m = 0; m < NREQ; m++) begin
            req_addr[AWID*m +: AWID] = d_addr[m];
            req_wrd[DWID*m +: DWID]  = d_wrd[m];
        end
    end

    initial begin
        req_t cur;
        d_vld = '0;
        d_wr  = '0;
        for (int m = 0; m < NREQ; m++) begin
            d_addr[m] = '0;
            d_wrd[m]  = '0;
        end
        forever begin
            @(posedge reg_clk);
            #1;
            for (int m = 0; m < NREQ; m++) begin
                if (acc_flag[m]) begin
                    acc_flag[m] = 1'b0;
                    if (mq[m].size() != 0) void'(mq[m].pop_front());
                end
                if (mq[m].size() != 0) begin
                    cur       = mq[m][0];
                    d_wr[m]   = cur.wr;
                    d_addr[m] = cur.addr;
                    d_wrd[m]  = cur.wrd;
                    d_vld[m]  = !(withdraw_en && $urandom_range(0, 5) == 0);
                end else begin
                    d_vld[m]  = 1'b0;
                    d_wr[m]   = 1'($urandom);
                    d_addr[m] = AWID'($urandom);
                    d_wrd[m]  = $urandom;
                end
            end
        end
    end

    // Reference model state and scoreboard.
    exp_t            exp_q [$];
    int              last_gnt = NREQ - 1;
    int              wait_cnt [NREQ];
    logic [DWID-1:0] hold_rdd = '0;
    logic [DWID-1:0] last_rdd [NREQ];
    logic            last_err [NREQ];
    int              rsp_cnt  [NREQ];
    int              gnt_log  [$];
    int unsigned     acc_log  [$];
    logic [BEW-1:0]  last_we = '0;
    int              ce_cnt = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] vld, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            int c;
            c = (last + off) % NREQ;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge reg_clk) begin
        exp_t            e;
        bit              idle;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        logic            exp_ce;
        logic [BEW-1:0]  exp_we;
        logic [AWID-1:0] exp_addr;
        logic [DWID-1:0] exp_wrd;
        if (sys_rst) begin
            chk("rst_outputs_zero",
                {63'd0, |{req_rdy, rsp_vld, rsp_err, rsp_rdd, busy, reg_ce, reg_we, reg_addr, reg_wrd}}, 64'd0);
        end else begin
            if (reg_ce) begin
                last_we = reg_we;
                ce_cnt++;
            end
            for (int m = 0; m < NREQ; m++) if (!req_vld[m]) wait_cnt[m] = 0;
            idle = (exp_q.size() == 0);
            chk("busy", busy, !idle);
            exp_ce = 1'b0; exp_we = '0; exp_addr = '0; exp_wrd = '0; exp_rsp = '0;
            e = '0;
            if (!idle) begin
                e = exp_q[0];
                if (cyc == e.acc + 1 && !e.err) begin
                    exp_ce   = 1'b1;
                    exp_we   = {BEW{e.wr}};
                    exp_addr = e.addr;
                    exp_wrd  = e.wrd;
                end
                if (cyc == e.acc + 2) exp_rsp = NREQ'(1) << e.m;
            end
            chk("bus_ce", reg_ce, exp_ce);
            chk("bus_we", reg_we, exp_we);
            chk("bus_addr", reg_addr, exp_addr);
            chk("bus_wrd", reg_wrd, exp_wrd);
            chk("rsp_vld", rsp_vld, exp_rsp);
            if (exp_rsp != '0) begin
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_rdd", rsp_rdd, e.rdd);
                hold_rdd    = e.rdd;
                last_rdd[e.m] = rsp_rdd;
                last_err[e.m] = rsp_err;
                rsp_cnt[e.m]++;
                void'(exp_q.pop_front());
            end else begin
                chk("rsp_err_quiet", rsp_err, 1'b0);
                chk("rsp_rdd_hold", rsp_rdd, hold_rdd);
            end
            exp_rdy = '0;
            g = -1;
            if (idle && req_vld != '0) begin
                g = rr_pick(req_vld, last_gnt);
                exp_rdy = NREQ'(1) << g;
            end
            chk("req_rdy", req_rdy, exp_rdy);
            if (g >= 0) begin
                for (int m = 0; m < NREQ; m++) if (m != g && req_vld[m]) wait_cnt[m]++;
                chk("no_starve", wait_cnt[g] <= NREQ - 1, 1'b1);
                wait_cnt[g] = 0;
                e      = '0;
                e.m    = 8'(g);
                e.wr   = d_wr[g];
                e.addr = d_addr[g];
                e.wrd  = d_wrd[g];
                e.err  = (d_addr[g] >= AWID'(REGCNT));
                e.old  = e.err ? '0 : model[d_addr[g][IW-1:0]];
                e.rdd  = e.old;
                if (e.wr && !e.err) model[d_addr[g][IW-1:0]] = d_wrd[g];
                e.acc  = cyc;
                exp_q.push_back(e);
                acc_flag[g] = 1'b1;
                last_gnt    = g;
                gnt_log.push_back(g);
                acc_log.push_back(cyc);
            end
        end
    end

    function automatic bit pending();
        for (int m = 0; m < NREQ; m++) if (mq[m].size() != 0 || acc_flag[m]) return 1'b1;
        return exp_q.size() != 0;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        @(negedge reg_clk); #2;
        while (pending() && n < 600) begin
            @(negedge reg_clk); #2;
            n++;
        end
        chk({nm, "_done"}, n < 600, 1'b1);
    endtask

    task automatic txn(input int m, input logic wr, input logic [AWID-1:0] addr,
                       input logic [DWID-1:0] wrd, input string nm);
        req_t r;
        r.wr = wr; r.addr = addr; r.wrd = wrd;
        mq[m].push_back(r);
        drain(nm);
    endtask

    function automatic logic [AWID-1:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return AWID'($urandom_range(0, REGCNT - 1));
        if (r < 9) return AWID'($urandom_range(REGCNT, REGCNT + 8));
        return AWID'($urandom_range(REGCNT, (1 << AWID) - 1));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DWID-1:0] init3;
        req_t            r;
        int              n;
        int              ce0;
        int              base [NREQ];
        int              issued [NREQ];

        for (int i = 0; i < REGCNT; i++) begin
            bank[i]  = (i == 0) ? 32'h0000_1234 : $urandom;
            model[i] = bank[i];
        end
        for (int m = 0; m < NREQ; m++) begin
            wait_cnt[m] = 0; rsp_cnt[m] = 0; last_rdd[m] = '0; last_err[m] = 1'b0;
        end
        init3 = bank[3];

        repeat (3) @(posedge reg_clk);
        #2 sys_rst = 1'b0;

        // 1: reset during the bus cycle of a write drops it; the master reissues.
        r.wr = 1'b1; r.addr = 12'd3; r.wrd = 32'hDEAD_0003;
        mq[0].push_back(r);
        n = 0;
        while (gnt_log.size() == 0 && n < 50) begin
            @(negedge reg_clk); #1;
            n++;
        end
        chk("t1_accept", gnt_log.size() != 0, 1'b1);
        @(posedge reg_clk); #2;
        chk("t1_issue_ce", reg_ce, 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("t1_rst_zero", {63'd0, |{req_rdy, rsp_vld, rsp_err, rsp_rdd, reg_ce, reg_we, reg_addr, reg_wrd}}, 64'd0);
        chk("t1_rst_busy", busy, 1'b0);
        if (exp_q.size() != 0 && exp_q[0].wr && !exp_q[0].err) model[exp_q[0].addr[IW-1:0]] = exp_q[0].old;
        exp_q.delete();
        last_gnt = NREQ - 1;
        hold_rdd = '0;
        mq[0].push_back(r);
        @(posedge reg_clk); @(posedge reg_clk); #2;
        chk("t1_no_write", bank[3], init3);
        chk("t1_no_rsp", rsp_cnt[0], 0);
        sys_rst = 1'b0;
        drain("t1_reissue");
        chk("t1_rsp_cnt", rsp_cnt[0], 1);
        chk("t1_old_val", last_rdd[0], init3);

        // 2: write then read back through another master.
        txn(0, 1'b1, 12'd5, 32'hA5A5_0001, "t2_wr");
        chk("t2_wr_we", last_we, 4'hF);
        txn(1, 1'b0, 12'd5, 32'h0, "t2_rd");
        chk("t2_rd_we", last_we, 4'h0);
        chk("t2_rdd", last_rdd[1], 32'hA5A5_0001);
        chk("t2_err", last_err[1], 1'b0);

        // 3: two masters contending alternate grants every three cycles.
        gnt_log.delete();
        acc_log.delete();
        for (int i = 0; i < 3; i++) begin
            r.wr = 1'b1; r.addr = AWID'(8 + i); r.wrd = $urandom;
            mq[0].push_back(r);
            r.wr = 1'b0; r.addr = AWID'(12 + i);
            mq[1].push_back(r);
        end
        drain("t3");
        chk("t3_count", gnt_log.size(), 6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++) begin
            chk("t3_gnt_order", gnt_log[i], i % 2);
            if (i > 0) chk("t3_spacing", acc_log[i] - acc_log[i-1], 3);
        end

        // 4: out-of-range addresses never reach the bus.
        ce0 = ce_cnt;
        txn(1, 1'b0, 12'd32, 32'h0, "t4_rd32");
        chk("t4_err", last_err[1], 1'b1);
        chk("t4_rdd", last_rdd[1], 32'h0);
        txn(0, 1'b1, 12'h825, 32'hBAD0_0825, "t4_alias");
        chk("t4_alias_err", last_err[0], 1'b1);
        chk("t4_no_ce", ce_cnt, ce0);
        chk("t4_bank5", bank[5], 32'hA5A5_0001);

        // 5: read-before-write value on a write, new value on the next read.
        txn(0, 1'b0, 12'd0, 32'h0, "t5_rd0");
        chk("t5_rd_init", last_rdd[0], 32'h0000_1234);
        txn(0, 1'b1, 12'd0, 32'h5555_AAAA, "t5_wr0");
        chk("t5_wr_old", last_rdd[0], 32'h0000_1234);
        txn(0, 1'b0, 12'd0, 32'h0, "t5_rd_new");
        chk("t5_rd_new", last_rdd[0], 32'h5555_AAAA);

        // 6: random mix from all masters, including withdrawn requests.
        for (int m = 0; m < NREQ; m++) begin
            base[m]   = rsp_cnt[m];
            issued[m] = 0;
        end
        withdraw_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge reg_clk); #3;
            for (int m = 0; m < NREQ; m++) begin
                if (mq[m].size() < 2 && $urandom_range(0, 3) == 0) begin
                    r.wr   = 1'($urandom);
                    r.addr = rnd_addr();
                    r.wrd  = $urandom;
                    mq[m].push_back(r);
                    issued[m]++;
                end
            end
        end
        withdraw_en = 1'b0;
        drain("t6");
        for (int m = 0; m < NREQ; m++) chk("t6_rsp_count", rsp_cnt[m] - base[m], issued[m]);
        for (int i = 0; i < REGCNT; i++) chk("bank_vs_model", bank[i], model[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
